lc3_fetch_stage: RTL
====================

Name: lc3_fetch_stage

Overview:
- LC-3 fetch stage driven by the fetch_in agent's control bus (enable_updatePC, enable_fetch, taddr, br_taken).
- Owns the program counter and issues instruction-memory reads over a request/valid handshake with variable latency.
- Holds the returned instruction for decode and squashes responses made stale by a PC redirect.
- Sits between the controller/execute redirect path (upstream) and decode (downstream).

Parameters:
- RESET_PC, 16'h3000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, maximum WAIT cycles before a read is abandoned and re-issued (legal range 2..255).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- enable_updatePC  input  1  advance or redirect PC this cycle
- enable_fetch  input  1  permit new instruction-memory requests
- taddr  input  16  branch/jump target address
- br_taken  input  1  select taddr (1) or npc (0) on PC update
- pc  output  16  current PC register
- npc  output  16  pc+1, combinational
- instrmem_rd  output  1  one-cycle read request strobe
- imem_addr  output  16  request address, valid while instrmem_rd=1
- imem_rvalid  input  1  read data valid (one-cycle pulse)
- imem_rdata  input  16  read data
- instr  output  16  held instruction
- instr_pc  output  16  address instr was fetched from
- instr_valid  output  1  instr/instr_pc valid for decode
- imem_timeout  output  1  one-cycle pulse when a read times out

Behaviour:
- Reset is asynchronous and active-high. Reset values:
  - pc=RESET_PC
  - instrmem_rd=0, imem_addr=0
  - instr=0, instr_pc=0, instr_valid=0
  - imem_timeout=0
  - squash=0, wait counter=0, state=IDLE
- npc = pc+1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
- PC update happens in every state:
  - At a clock edge with enable_updatePC=1: pc <= br_taken ? taddr : npc.
  - enable_updatePC=0: pc holds.
  - br_taken is ignored when enable_updatePC=0.
- FSM state IDLE:
  - instrmem_rd=0; imem_rvalid is ignored.
  - enable_fetch=1 -> REQ.
- FSM state REQ (exactly one cycle):
  - instrmem_rd=1, imem_addr=pc; req_addr latched from pc; squash cleared; wait counter cleared.
  - If enable_updatePC=1 in this same cycle, squash is set, since the request carries the old pc.
  - Next state is WAIT.
- FSM state WAIT:
  - Wait counter increments each cycle. enable_updatePC=1 in any WAIT cycle sets squash.
  - imem_rvalid=1 with squash=0 and enable_updatePC=0: instr<=imem_rdata, instr_pc<=req_addr, instr_valid<=1, next state HOLD.
  - imem_rvalid=1 with squash=1, or with enable_updatePC=1 in the same cycle: data is discarded; next state REQ if enable_fetch=1, else IDLE.
  - Counter reaches TIMEOUT_CYCLES with no rvalid: imem_timeout pulses for 1 cycle; next state REQ if enable_fetch=1, else IDLE.
  - enable_fetch=0 in WAIT does not abort an outstanding read.
- FSM state HOLD:
  - instr, instr_pc and instr_valid are held stable.
  - enable_updatePC=1: instr_valid<=0 at that edge; next state REQ if enable_fetch=1, else IDLE.
  - imem_rvalid is ignored.
- Latency: enable_fetch is asserted in IDLE, then REQ follows next cycle. With a response N cycles after the strobe, instr_valid rises N+1 cycles after the strobe. Minimum N=1.
- Only one read is ever outstanding.
- A stray imem_rvalid in IDLE, REQ or HOLD, including a late response after reset, is ignored.
- Reset mid-read: the outstanding response is dropped; the first post-reset request uses RESET_PC.

Decomposition:
- Shared package fetch_stage_pkg holds:
  - fetch_state_t enum (IDLE, REQ, WAIT, HOLD)
  - LC3_RESET_PC constant (16'h3000)
  - word_t (logic [15:0])
  - TIMEOUT_W = $clog2(255+1)
- Sub-module lc3_pc_reg: the PC register, npc adder and taddr/npc mux. The FSM, capture and timeout logic stay in the top.

Test Plan:
- Reset, enable_fetch=1, memory latency 2, rdata=16'h1234 -> instrmem_rd pulses with imem_addr=3000; 3 cycles later instr=1234, instr_pc=3000, instr_valid=1.
- In HOLD, enable_updatePC=1 with br_taken=0 -> pc=3001, instr_valid drops, next request at 3001.
- In WAIT, enable_updatePC=1 with br_taken=1 and taddr=16'h4000 -> response at 3000 discarded, instr_valid stays 0, next request imem_addr=4000.
- pc=16'hFFFF, enable_updatePC=1, br_taken=0 -> npc was 0000 and pc becomes 0000.
- No rvalid for TIMEOUT_CYCLES=16 cycles -> imem_timeout pulses once, request re-issued at the same pc. A late rvalid arriving in REQ is ignored.
- Reset asserted mid-WAIT, then the response arrives -> all outputs are at reset values, the response is ignored, and the next request is at 3000.

Source files
------------

// File: rtl/lc3_fetch_stage_pkg.sv
// Shared types and constants for the LC-3 fetch stage.
package fetch_stage_pkg;

    typedef logic [15:0] word_t;

    // Fetch controller states, in request-lifecycle order.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam word_t LC3_RESET_PC = 16'h3000;

    // Wide enough for the largest legal timeout (255 cycles).
    localparam int TIMEOUT_W = $clog2(255 + 1);

endpackage

// File: rtl/lc3_fetch_stage_if.sv
// Instruction-memory read port between the fetch stage and instruction memory.
//
// Handshake: the fetch stage raises instrmem_rd for exactly one cycle with
// imem_addr valid in that same cycle; there is no ready/backpressure.
// Memory answers some cycles later with a one-cycle imem_rvalid pulse and
// imem_rdata valid in that same cycle. At most one read is outstanding, so
// a response always belongs to the most recent strobe. The fetch stage
// ignores any imem_rvalid that arrives while it is not waiting.
interface lc3_fetch_stage_if;
    import fetch_stage_pkg::*;

    logic  instrmem_rd;
    word_t imem_addr;
    logic  imem_rvalid;
    word_t imem_rdata;

    modport master (
        output instrmem_rd,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  instrmem_rd,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/lc3_fetch_stage_pc_reg.sv
// Program counter register with its +1 adder and target/sequential mux.
module lc3_pc_reg
    import fetch_stage_pkg::*;
#(
    parameter word_t RESET_PC = LC3_RESET_PC
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  enable_updatePC,
    input  logic  br_taken,
    input  word_t taddr,
    output word_t pc,
    output word_t npc
);

    // Sequential successor; wraps FFFF -> 0000 naturally at 16 bits.
    assign npc = pc + 16'd1;

    // PC advances or redirects only when the controller enables an update.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (enable_updatePC) begin
            pc <= br_taken ? taddr : npc;
        end
    end

endmodule

// File: rtl/lc3_fetch_stage.sv
// LC-3 fetch stage: owns the PC, issues one instruction read at a time,
// holds the returned instruction for decode and drops stale responses.
module lc3_fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter word_t RESET_PC       = LC3_RESET_PC,
    // Legal range 2..255.
    parameter int    TIMEOUT_CYCLES = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable_updatePC,
    input  logic                     enable_fetch,
    input  word_t                    taddr,
    input  logic                     br_taken,
    output word_t                    pc,
    output word_t                    npc,
    lc3_fetch_stage_if.master        imem,
    output word_t                    instr,
    output word_t                    instr_pc,
    output logic                     instr_valid,
    output logic                     imem_timeout,
    output fetch_state_t             state_dbg
);

    // Value of the wait counter during the last WAIT cycle before giving up.
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    fetch_state_t           state;
    fetch_state_t           state_next;
    word_t                  req_addr;
    logic                   squash;
    logic [TIMEOUT_W-1:0]   wait_cnt;
    logic                   rsp_accept;
    logic                   rsp_drop;
    logic                   rsp_timeout;

    lc3_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clock           (clock),
        .reset           (reset),
        .enable_updatePC (enable_updatePC),
        .br_taken        (br_taken),
        .taddr           (taddr),
        .pc              (pc),
        .npc             (npc)
    );

    assign state_dbg = state;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; an abandoned or stale read goes straight back to REQ
    // only while fetching is still permitted.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable_fetch) state_next = REQ;
            end
            REQ: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (rsp_accept) begin
                    state_next = HOLD;
                end else if (rsp_drop || rsp_timeout) begin
                    state_next = enable_fetch ? REQ : IDLE;
                end
            end
            HOLD: begin
                if (enable_updatePC) state_next = enable_fetch ? REQ : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs and response classification; rvalid only matters in WAIT, and
    // a response is stale if any PC update happened since the strobe or in
    // the response cycle itself.
    always_comb begin
        imem.instrmem_rd = 1'b0;
        imem.imem_addr   = '0;
        rsp_accept       = 1'b0;
        rsp_drop         = 1'b0;
        rsp_timeout      = 1'b0;
        case (state)
            REQ: begin
                imem.instrmem_rd = 1'b1;
                imem.imem_addr   = pc;
            end
            WAIT: begin
                if (imem.imem_rvalid) begin
                    if (squash || enable_updatePC) begin
                        rsp_drop = 1'b1;
                    end else begin
                        rsp_accept = 1'b1;
                    end
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    rsp_timeout = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Per-request bookkeeping: requested address, stale flag and wait count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_addr <= '0;
            squash   <= 1'b0;
            wait_cnt <= '0;
        end else begin
            case (state)
                REQ: begin
                    req_addr <= pc;
                    squash   <= enable_updatePC;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (enable_updatePC) squash <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Instruction hold register presented to decode.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (rsp_accept) begin
            instr       <= imem.imem_rdata;
            instr_pc    <= req_addr;
            instr_valid <= 1'b1;
        end else if (state == HOLD && enable_updatePC) begin
            instr_valid <= 1'b0;
        end
    end

    // One-cycle timeout pulse, coinciding with the re-issue cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            imem_timeout <= 1'b0;
        end else begin
            imem_timeout <= rsp_timeout;
        end
    end

endmodule
